// File: rtl/spi_flash_responder_if.sv
// Pin and memory-port bundle for spi_flash_responder.
// The master side is the SPI host plus the backing byte memory; the slave side is the responder.
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
) ();
  logic              spi_sck;
  logic              spi_cs;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_wr;
  logic [7:0]        mem_wdata;

  modport master (
    output spi_sck, spi_cs, spi_mosi, mem_rdata,
    input  spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  spi_sck, spi_cs, spi_mosi, mem_rdata,
    output spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash responder (JEDEC ID, status, read, power-down), oversampled in clk_48mhz.
// Define SPI_FLASH_PROGRAM_EN to add write-enable/disable and page program (0x06/0x04/0x02).
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          ADDR_W      = 24,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  spi_flash_responder_if.slave  bus,
  output logic                  powered_down
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ID     = 3'd2;
  localparam logic [2:0] ST_STAT   = 3'd3;
  localparam logic [2:0] ST_ADDR   = 3'd4;
  localparam logic [2:0] ST_READ   = 3'd5;
  localparam logic [2:0] ST_PROG   = 3'd6;
  localparam logic [2:0] ST_IGNORE = 3'd7;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic              sck_prev, cs_prev;
  logic              sck_s, cs_s, mosi_s;
  logic              sck_rise, sck_fall, cs_rise, cs_fall, byte_done;
  logic [2:0]        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_in, shift_out, byte_in, status_byte, rise_op;
  logic [1:0]        id_idx, addr_cnt;
  logic [ADDR_W-1:0] addr_acc, mem_addr_q;
  logic              is_prog, miso_q, miso_oe_q, mem_rd_q, rd_pend;
  logic              wel;

`ifdef SPI_FLASH_PROGRAM_EN
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(24'h0000FF);
  logic              mem_wr_q;
  logic [7:0]        mem_wdata_q;
  logic [ADDR_W-1:0] addr_inc, page_inc;

  assign addr_inc      = mem_addr_q + ADDR_W'(1);
  assign page_inc      = (mem_addr_q & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
`else
  assign wel           = 1'b0;
  assign bus.mem_wr    = 1'b0;
  assign bus.mem_wdata = 8'h00;
`endif

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign cs_rise     = cs_s & ~cs_prev;
  assign cs_fall     = ~cs_s & cs_prev;
  assign byte_done   = sck_rise && (bit_cnt == 3'd7);
  assign byte_in     = {shift_in[6:0], mosi_s};
  assign status_byte = {6'b0, wel, 1'b0};

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = miso_oe_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;

  // NOTE: cs synchronisers reset high so the responder leaves reset deselected, not seeing a false cs fall.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      shift_in     <= 8'h00;
      shift_out    <= 8'h00;
      rise_op      <= 8'h00;
      id_idx       <= 2'd0;
      addr_cnt     <= 2'd0;
      addr_acc     <= '0;
      is_prog      <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      rd_pend      <= 1'b0;
      powered_down <= 1'b0;
`ifdef SPI_FLASH_PROGRAM_EN
      wel          <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
`endif
    end else begin
      // NOTE: strobes default low every cycle, so a single assignment below is exactly a one-cycle pulse.
      mem_rd_q  <= 1'b0;
      rd_pend   <= mem_rd_q;
      miso_oe_q <= ~cs_s;
`ifdef SPI_FLASH_PROGRAM_EN
      mem_wr_q  <= 1'b0;
`endif
      if (cs_rise) begin
        // Deselect wins over any sck edge in the same cycle; a partial byte is simply dropped.
        state     <= ST_IDLE;
        bit_cnt   <= 3'd0;
        shift_out <= 8'h00;
        miso_q    <= 1'b0;
        rd_pend   <= 1'b0;
        rise_op   <= 8'h00;
        case (rise_op)
          8'hB9: powered_down <= 1'b1;
          8'hAB: powered_down <= 1'b0;
`ifdef SPI_FLASH_PROGRAM_EN
          8'h06: wel <= 1'b1;
          8'h04: wel <= 1'b0;
          8'h02: wel <= 1'b0;
`endif
          default: ;
        endcase
      end else if (cs_fall) begin
        state     <= ST_CMD;
        bit_cnt   <= 3'd0;
        shift_in  <= 8'h00;
        shift_out <= 8'h00;
        miso_q    <= 1'b0;
        rise_op   <= 8'h00;
      end else if (state != ST_IDLE) begin
        if (sck_fall) begin
          miso_q    <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
        if (sck_rise) begin
          shift_in <= byte_in;
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            ST_CMD: begin
              state     <= ST_IGNORE;
              shift_out <= 8'h00;
              if (!powered_down || byte_in == 8'hAB) begin
                case (byte_in)
                  8'h9F: begin
                    state     <= ST_ID;
                    shift_out <= JEDEC_ID[23:16];
                    id_idx    <= 2'd1;
                  end
                  8'h05: begin
                    state     <= ST_STAT;
                    shift_out <= status_byte;
                  end
                  8'h03: begin
                    state    <= ST_ADDR;
                    addr_cnt <= 2'd0;
                    is_prog  <= 1'b0;
                  end
                  8'hB9, 8'hAB: rise_op <= byte_in;
`ifdef SPI_FLASH_PROGRAM_EN
                  8'h06, 8'h04: rise_op <= byte_in;
                  8'h02: begin
                    if (wel) begin
                      state    <= ST_ADDR;
                      addr_cnt <= 2'd0;
                      is_prog  <= 1'b1;
                      rise_op  <= byte_in;
                    end
                  end
`endif
                  default: ;
                endcase
              end
            end
            ST_ID: begin
              case (id_idx)
                2'd0:    shift_out <= JEDEC_ID[23:16];
                2'd1:    shift_out <= JEDEC_ID[15:8];
                default: shift_out <= JEDEC_ID[7:0];
              endcase
              id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
            end
            ST_STAT: shift_out <= status_byte;
            ST_ADDR: begin
              // Keeping only the low ADDR_W bits while shifting truncates the 24-bit address.
              addr_acc <= ADDR_W'({addr_acc, byte_in});
              addr_cnt <= addr_cnt + 2'd1;
              if (addr_cnt == 2'd2) begin
                mem_addr_q <= ADDR_W'({addr_acc, byte_in});
                if (is_prog) begin
                  state <= ST_PROG;
                end else begin
                  state    <= ST_READ;
                  mem_rd_q <= 1'b1;
                end
              end
            end
            ST_READ: mem_rd_q <= 1'b1;
            ST_PROG: begin
`ifdef SPI_FLASH_PROGRAM_EN
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= byte_in;
`endif
            end
            default: ;
          endcase
        end
        // Read data arrives two cycles after the rise, well before the fall that presents bit 7.
        if (rd_pend) begin
          shift_out  <= bus.mem_rdata;
          mem_addr_q <= mem_addr_q + ADDR_W'(1);
        end
`ifdef SPI_FLASH_PROGRAM_EN
        if (mem_wr_q) mem_addr_q <= page_inc;
`endif
      end
    end
  end

endmodule
